slc3_mem_ctrl: RTL and testbench
================================

// Module: slc3_mem_ctrl
// PURPOSE
//  Parametrised memory/I-O controller for the SLC-3 class CPU. It generalises the fixed-timing Mem2IO/tristate path.
//  Takes a req/ack transaction from the CPU and runs a multi-cycle async-SRAM cycle with programmable wait states.
//  One address (IO_ADDR) is decoded to the switch/hex-display I/O port.
//  Sits between the datapath (MAR/MDR) and the board SRAM pins plus the tristate pad buffer.
// PARAMETERS
//  DATA_W       16       data width, CPU and SRAM
//  CPU_ADDR_W   16       CPU address width
//  ADDR_W       20       SRAM pin address width (>= CPU_ADDR_W), zero-extended
//  WAIT_STATES  2        SRAM access wait cycles, legal range 1..15
//  IO_ADDR      16'hFFFF address decoded as I/O instead of SRAM
//  NUM_HEX      4        hex digits held in the display register
// PORTS
//  Clk          in   1              system clock, rising edge
//  Reset        in   1              asynchronous, active-low reset
//  req          in   1              CPU request, sampled in IDLE only
//  we           in   1              1 = write, 0 = read, sampled with req
//  addr         in   CPU_ADDR_W     CPU address, sampled with req
//  wdata        in   DATA_W         write data, sampled with req
//  ack          out  1              one-cycle completion pulse
//  rdata        out  DATA_W         read data, valid from ack and held until next read ack
//  busy         out  1              1 from the cycle after req is accepted until ack inclusive
//  ADDR         out  ADDR_W         SRAM address
//  CE_n,OE_n,WE_n,UB_n,LB_n out 1   SRAM strobes, active-low
//  sram_wdata   out  DATA_W         to tristate Data_write
//  sram_oe      out  1              tristate output enable; 1 = drive pads
//  sram_rdata   in   DATA_W         from tristate Data_read
//  Switches     in   DATA_W         board switches
//  hex_out      out  4*NUM_HEX      display register, digit 0 in the LSBs
// BEHAVIOUR
//  Reset (async, Reset=0), applied immediately:
//   - state=IDLE; ack=0, busy=0, rdata=0, hex_out=0, ADDR=0, sram_wdata=0, sram_oe=0.
//   - CE_n=OE_n=WE_n=UB_n=LB_n=1.
//   - Mid-transaction reset aborts the transaction with no ack; the CPU must reissue.
//  FSM: IDLE, SETUP, WAIT, DONE, IO.
//   - IDLE: req=1 latches we/addr/wdata. Goes to IO if addr==IO_ADDR, else SETUP.
//   - SETUP: ADDR={0,addr}, CE_n=0; read: OE_n=0; write: sram_oe=1. Load wait counter with WAIT_STATES-1.
//   - WAIT: strobes held; write also drives WE_n=0. Decrement counter; go to DONE at 0.
//   - DONE: WE_n=1 (write data and ADDR still held for hold time).
//     Read captures sram_rdata into rdata at the end of the last WAIT cycle. ack=1 -> IDLE.
//   - IO: ack=1; read: rdata<=Switches; write: hex_out<=wdata[4*NUM_HEX-1:0] (zero-padded if DATA_W smaller). -> IDLE.
//  Latency, counted in cycles after req is sampled in IDLE at edge 0:
//   - SRAM: ack high in cycle WAIT_STATES+2.
//   - I/O: ack high in cycle 1.
//  - After ack the FSM always returns to IDLE. A req held high starts the next transaction on the following edge.
//    Minimum spacing between SRAM acks is therefore WAIT_STATES+3.
//  - req, we, addr and wdata changes while busy are ignored; the latched copies are used.
//  - CE_n, OE_n and WE_n are registered, so they never glitch. OE_n and WE_n are never low in the same cycle.
//  - sram_oe=0 whenever we=0. ADDR holds its last value while IDLE.
// CONFIGURATION
//  SLC3_MEM_BYTE_EN
//   - Defined: adds input be[1:0], sampled with req. UB_n=~be[1], LB_n=~be[0] during SETUP/WAIT/DONE.
//     be=00 completes with ack but never pulls CE_n low. Requires DATA_W==16.
//   - Undefined: no be port. UB_n=LB_n=CE_n (word access only).
// TESTING
//  - Reset low mid-run: all strobes 1, ack/busy 0, hex_out 0 in the same cycle, with no clock edge needed.
//  - WAIT_STATES=2: write addr=0x3000, wdata=0xBEEF. ack at cycle 4; WE_n low exactly in cycles 2-3; sram_oe=1 in cycles 1-4.
//  - Read addr=0x3000 with SRAM model returning 0xBEEF. ack at cycle 4 with rdata=0xBEEF; OE_n low in cycles 1-3; WE_n stays 1.
//  - Switches=0x1234, read addr=0xFFFF: ack at cycle 1, rdata=0x1234, CE_n stays 1.
//    Write 0xFFFF with wdata=0xABCD: hex_out=0xABCD.
//  - req held high for 3 SRAM reads: 3 acks spaced 5 cycles apart. addr toggled while busy: ADDR unchanged.
//  - SLC3_MEM_BYTE_EN, be=10, write: UB_n=0, LB_n=1 during access. be=00: ack at cycle 4, CE_n never 0.

Source files
------------

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: memory / I-O controller for an SLC-3 class CPU.
//
// The CPU issues a req/ack transaction. The controller then either runs a
// multi-cycle async-SRAM access with WAIT_STATES wait cycles, or, when the
// address is IO_ADDR, completes in one cycle against the switch / hex I/O port.
//
// Ports
//   Clk, Reset           clock (rising edge), async active-low reset
//   req/we/addr/wdata    CPU request, sampled only while idle
//   be[1:0]              byte enables (only with SLC3_MEM_BYTE_EN defined)
//   ack, rdata, busy     completion pulse, read data (held), in-flight flag
//   ADDR, CE_n, OE_n,
//   WE_n, UB_n, LB_n     SRAM pins; every strobe is a registered output
//   sram_wdata, sram_oe  to the tristate pad buffer (sram_oe=1 drives pads)
//   sram_rdata           from the tristate pad buffer
//   Switches, hex_out    board I/O; hex digit 0 is in the LSBs
//
// Build option: define SLC3_MEM_BYTE_EN to add the be port (DATA_W must be 16).
// When it is undefined, UB_n and LB_n follow CE_n.
module slc3_mem_ctrl #(
  parameter int                    DATA_W      = 16,
  parameter int                    CPU_ADDR_W  = 16,
  parameter int                    ADDR_W      = 20,
  parameter int                    WAIT_STATES = 2,
  parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = 16'hFFFF,
  parameter int                    NUM_HEX     = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [CPU_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
`ifdef SLC3_MEM_BYTE_EN
  input  logic [1:0]            be,
`endif
  output logic                  ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     ADDR,
  output logic                  CE_n,
  output logic                  OE_n,
  output logic                  WE_n,
  output logic                  UB_n,
  output logic                  LB_n,
  output logic [DATA_W-1:0]     sram_wdata,
  output logic                  sram_oe,
  input  logic [DATA_W-1:0]     sram_rdata,
  input  logic [DATA_W-1:0]     Switches,
  output logic [4*NUM_HEX-1:0]  hex_out
);

  localparam int         HEX_W   = 4 * NUM_HEX;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE, S_IO} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             we_l;
  logic             en_l;    // access actually touches the SRAM (be != 00)
  logic             en_in;
  logic [HEX_W-1:0] wd_hex;

`ifdef SLC3_MEM_BYTE_EN
  assign en_in = |be;
`else
  assign en_in = 1'b1;
`endif

  // Display register takes the low bits of wdata, zero-padded if narrower.
  if (DATA_W >= HEX_W) begin : g_hex_trunc
    assign wd_hex = wdata[HEX_W-1:0];
  end else begin : g_hex_pad
    assign wd_hex = {{(HEX_W-DATA_W){1'b0}}, wdata};
  end

  // Strobes are driven on the edge that enters each state, so SETUP sees
  // CE_n/OE_n already asserted and the WAIT/DONE edges only change WE_n/OE_n.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_l       <= 1'b0;
      en_l       <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      hex_out    <= '0;
      ADDR       <= '0;
      sram_wdata <= '0;
      sram_oe    <= 1'b0;
      CE_n       <= 1'b1;
      OE_n       <= 1'b1;
      WE_n       <= 1'b1;
      UB_n       <= 1'b1;
      LB_n       <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          we_l <= we;
          busy <= 1'b1;
          if (addr == IO_ADDR) begin
            // I/O completes in one cycle; the ack lands in the IO state.
            state <= S_IO;
            ack   <= 1'b1;
            if (we) hex_out <= wd_hex;
            else    rdata   <= Switches;
          end else begin
            state   <= S_SETUP;
            en_l    <= en_in;
            ADDR    <= ADDR_W'(addr);
            sram_oe <= we;
            if (we) sram_wdata <= wdata;
            CE_n    <= ~en_in;
            OE_n    <= ~(en_in & ~we);
`ifdef SLC3_MEM_BYTE_EN
            UB_n    <= ~be[1];
            LB_n    <= ~be[0];
`else
            UB_n    <= ~en_in;
            LB_n    <= ~en_in;
`endif
          end
        end
        S_SETUP: begin
          state <= S_WAIT;
          cnt   <= WS_LOAD;
          WE_n  <= ~(en_l & we_l);
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            // Last wait cycle: sample read data while OE_n is still low.
            state <= S_DONE;
            ack   <= 1'b1;
            WE_n  <= 1'b1;
            OE_n  <= 1'b1;
            if (!we_l) rdata <= sram_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          // ADDR and sram_wdata stay put through DONE for SRAM hold time.
          state   <= S_IDLE;
          busy    <= 1'b0;
          CE_n    <= 1'b1;
          UB_n    <= 1'b1;
          LB_n    <= 1'b1;
          sram_oe <= 1'b0;
        end
        S_IO: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// tb_slc3_mem_ctrl: random req/ack traffic against a transaction-level model
// (word memory, display register, last read value, last SRAM address) plus a
// pin-level SRAM model that the DUT actually drives.
module tb_slc3_mem_ctrl;
  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        ack, busy, CE_n, OE_n, WE_n, UB_n, LB_n, sram_oe;
  logic [15:0] rdata, sram_wdata, sram_rdata, hex_out;
  logic [15:0] Switches = '0;
  logic [19:0] ADDR;
`ifdef SLC3_MEM_BYTE_EN
  logic [1:0]  be = 2'b11;
`endif

  always #5 Clk = ~Clk;

  slc3_mem_ctrl #(.WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef SLC3_MEM_BYTE_EN
    .be(be),
`endif
    .ack(ack), .rdata(rdata), .busy(busy), .ADDR(ADDR),
    .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .UB_n(UB_n), .LB_n(LB_n),
    .sram_wdata(sram_wdata), .sram_oe(sram_oe), .sram_rdata(sram_rdata),
    .Switches(Switches), .hex_out(hex_out)
  );

  // Pin-level async SRAM: 16 words, address bits [3:0].
  logic [15:0] sram [16] = '{default: 16'h0};
  always @(posedge Clk) if (!CE_n && !WE_n) sram[ADDR[3:0]] <= sram_wdata;
  assign sram_rdata = (!CE_n && !OE_n) ? sram[ADDR[3:0]] : 16'hDEAD;

  // Transaction-level reference.
  logic [15:0] ref_mem [16] = '{default: 16'h0};
  logic [15:0] m_rdata = '0, m_hex = '0;
  logic [19:0] m_addr = '0;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d);
    int lat = 0, we_lo = 0, oe_lo = 0, ce_lo = 0, soe = 0;
    bit addr_ok = 1, busy_ok = 1, excl_ok = 1;
    bit io;
    bit sram_w, sram_r;
    io = (a == 16'hFFFF);
    sram_w = !io && w;
    sram_r = !io && !w;
    @(negedge Clk);
    chk("idle_ack_busy", {ack, busy}, 2'b00);
    req = 1'b1; we = w; addr = a; wdata = d;
    if (!io) m_addr = {4'h0, a};
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        // Everything after the sampling edge is noise the DUT must ignore.
        req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
      end
      if (!WE_n) we_lo++;
      if (!OE_n) oe_lo++;
      if (!CE_n) ce_lo++;
      if (sram_oe) soe++;
      if (!OE_n && !WE_n) excl_ok = 0;
      if (ADDR !== m_addr) addr_ok = 0;
      if (!busy) busy_ok = 0;
      if (ack) begin lat = n; break; end
    end
    if (io) begin
      if (w) m_hex = d; else m_rdata = Switches;
    end else begin
      if (w) ref_mem[a[3:0]] = d; else m_rdata = ref_mem[a[3:0]];
    end
    chk("latency", lat, io ? 1 : WS + 2);
    chk("we_low_cycles", we_lo, sram_w ? WS : 0);
    chk("oe_low_cycles", oe_lo, sram_r ? WS + 1 : 0);
    chk("ce_low_cycles", ce_lo, io ? 0 : WS + 2);
    chk("sram_oe_cycles", soe, sram_w ? WS + 2 : 0);
    chk("addr_held", addr_ok, 1);
    chk("busy_span", busy_ok, 1);
    chk("oe_we_excl", excl_ok, 1);
    chk("rdata", rdata, m_rdata);
    chk("hex_out", hex_out, m_hex);
  endtask

  initial begin
    int acks[$];

    // Reset state while Reset is held low.
    #12;
    chk("rst_strobes", {CE_n, OE_n, WE_n, UB_n, LB_n}, 5'h1f);
    chk("rst_ack_busy", {ack, busy, sram_oe}, 3'b000);
    chk("rst_data", {rdata, hex_out}, 32'h0);
    chk("rst_addr", ADDR, 20'h0);
    @(negedge Clk); Reset = 1'b1;

    // Directed cases.
    txn(1'b1, 16'h3000, 16'hBEEF);
    txn(1'b0, 16'h3000, 16'h0000);
    chk("beef_read", rdata, 16'hBEEF);
    Switches = 16'h1234;
    txn(1'b0, 16'hFFFF, 16'h0000);
    chk("switch_read", rdata, 16'h1234);
    txn(1'b1, 16'hFFFF, 16'hABCD);
    chk("hex_write", hex_out, 16'hABCD);

    // req held high across three SRAM reads.
    txn(1'b1, 16'h3005, 16'h5A5A);
    @(negedge Clk);
    req = 1'b1; we = 1'b0; addr = 16'h3005;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (ack) begin
        acks.push_back(n);
        chk("b2b_rdata", rdata, ref_mem[5]);
        if (acks.size() == 3) begin req = 1'b0; break; end
      end
    end
    m_rdata = ref_mem[5];
    chk("b2b_count", acks.size(), 3);
    if (acks.size() == 3) begin
      chk("b2b_first", acks[0], WS + 2);
      chk("b2b_gap1", acks[1] - acks[0], WS + 3);
      chk("b2b_gap2", acks[2] - acks[1], WS + 3);
    end

    // Random traffic, mixing SRAM and I/O.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      Switches = 16'($urandom);
      a = ($urandom_range(0, 4) == 0) ? 16'hFFFF : (16'h3000 | 16'($urandom_range(0, 15)));
      txn(1'($urandom), a, 16'($urandom));
    end

    // Ensure the display is non-zero, then abort a write in SETUP with reset.
    txn(1'b1, 16'hFFFF, 16'hABCD);
    @(negedge Clk);
    req = 1'b1; we = 1'b1; addr = 16'h3007; wdata = 16'h5555;
    @(negedge Clk);
    req = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("abort_strobes", {CE_n, OE_n, WE_n, UB_n, LB_n}, 5'h1f);
    chk("abort_ack_busy", {ack, busy, sram_oe}, 3'b000);
    chk("abort_hex", hex_out, 16'h0);
    @(negedge Clk); Reset = 1'b1;
    m_hex = '0; m_rdata = '0; m_addr = '0;
    txn(1'b0, 16'h3007, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
